// File: rtl/eth_fcs_checker.sv
// eth_fcs_checker: receive-side Ethernet FCS checker.
// Runs a reflected CRC-32 over every accepted byte of a frame, FCS included,
// and reports pass/fail, runt and length one cycle after the eof byte.
// The byte stream is forwarded with one cycle of latency.
// Build option: define FCS_STRIP_EN to forward through a 4-byte delay line
// so the trailing FCS bytes are never forwarded.
module eth_fcs_checker #(
    parameter int MIN_LEN = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  din,
    input  logic        din_valid,
    input  logic        din_sof,
    input  logic        din_eof,
    output logic [7:0]  dout,
    output logic        dout_valid,
    output logic        dout_sof,
    output logic        dout_eof,
    output logic        frame_done,
    output logic        fcs_ok,
    output logic        fcs_err,
    output logic        runt_err,
    output logic [15:0] frame_len
);

    localparam logic [31:0] CRC_INIT  = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY  = 32'hEDB8_8320;
    localparam logic [31:0] RESIDUE   = 32'hDEBB_20E3;
    localparam logic [15:0] MIN_LEN_W = 16'(MIN_LEN);

    typedef enum logic {IDLE, RECV} state_t;

    state_t      state;
    state_t      state_next;
    logic        accept;
    logic        start;
    logic        last;
    logic [31:0] crc;
    logic [31:0] crc_next;
    logic [15:0] cnt;
    logic [15:0] cnt_next;

    // One byte of the reflected CRC-32, LSB of the byte processed first.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        end
        return r;
    endfunction

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: sof (re)starts a frame, eof inside a frame ends it; bubbles hold.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
        state_next = state;
        if (din_valid) begin
            if (din_sof) begin
                state_next = din_eof ? IDLE : RECV;
            end else if (state == RECV && din_eof) begin
                state_next = IDLE;
            end
        end
    end

    // Per-cycle controls: which bytes belong to a frame, where it starts and ends.
    always_comb begin
        accept = din_valid && (din_sof || state == RECV);
        start  = din_valid && din_sof;
        last   = accept && din_eof;
    end

    // Next CRC and length; a sof byte reseeds both, abandoning any open frame.
    always_comb begin
        crc_next = crc_byte(start ? CRC_INIT : crc, din);
        if (start) begin
            cnt_next = 16'd1;
        end else begin
            cnt_next = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
        end
    end

    // CRC register and byte counter advance only on accepted bytes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= CRC_INIT;
            cnt <= 16'd0;
        end else if (accept) begin
            if (last) begin
                crc <= CRC_INIT;
                cnt <= 16'd0;
            end else begin
                crc <= crc_next;
                cnt <= cnt_next;
            end
        end
    end

    // Result fields load with the frame_done pulse and hold until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done <= 1'b0;
            fcs_ok     <= 1'b0;
            fcs_err    <= 1'b0;
            runt_err   <= 1'b0;
            frame_len  <= 16'd0;
        end else begin
            frame_done <= last;
            if (last) begin
                fcs_ok    <= (crc_next == RESIDUE);
                fcs_err   <= (crc_next != RESIDUE);
                runt_err  <= (cnt_next < MIN_LEN_W);
                frame_len <= cnt_next;
            end
        end
    end

`ifdef FCS_STRIP_EN
    logic [7:0] dly [4];
    logic [2:0] fill;
    logic       first;

    // Delay line advances on accepted bytes; once four bytes are held, each new
    // byte pushes out the oldest, so the last four (the FCS) are never emitted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the delay line is tiny, so it is reset along with its control; it is never read before being filled anyway.
            for (int i = 0; i < 4; i++) begin
                dly[i] <= 8'd0;
            end
            fill       <= 3'd0;
            first      <= 1'b0;
            dout       <= 8'd0;
            dout_valid <= 1'b0;
            dout_sof   <= 1'b0;
            dout_eof   <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            dout_sof   <= 1'b0;
            dout_eof   <= 1'b0;
            if (accept) begin
                dly[0] <= din;
                for (int i = 1; i < 4; i++) begin
                    dly[i] <= dly[i-1];
                end
                if (start) begin
                    fill  <= 3'd1;
                    first <= 1'b1;
                end else if (fill == 3'd4) begin
                    dout       <= dly[3];
                    dout_valid <= 1'b1;
                    dout_sof   <= first;
                    dout_eof   <= din_eof;
                    first      <= 1'b0;
                end else begin
                    fill <= fill + 3'd1;
                end
            end
        end
    end
`else
    // Frame bytes are forwarded straight through one register stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout       <= 8'd0;
            dout_valid <= 1'b0;
            dout_sof   <= 1'b0;
            dout_eof   <= 1'b0;
        end else begin
            dout_valid <= accept;
            dout_sof   <= accept && din_sof;
            dout_eof   <= accept && din_eof;
            if (accept) begin
                dout <= din;
            end
        end
    end
`endif

endmodule

// File: doc/eth_fcs_checker.md
ETH_FCS_CHECKER -- requirements
Module: eth_fcs_checker

Interface
REQ-001 The block SHALL have one parameter: MIN_LEN, default 64, minimum legal frame length in bytes including FCS.
REQ-002 clk  input  1  single clock; all logic SHALL be rising-edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 din  input  8  received byte, FCS appended as the last 4 bytes, least-significant byte first.
REQ-005 din_valid  input  1  din qualifier; low cycles are bubbles.
REQ-006 din_sof  input  1  first byte of frame; ignored unless din_valid=1.
REQ-007 din_eof  input  1  last byte of frame; ignored unless din_valid=1.
REQ-008 dout  output  8  forwarded byte.
REQ-009 dout_valid / dout_sof / dout_eof  output  1 each  forwarded qualifiers.
REQ-010 frame_done  output  1  one-cycle pulse: result fields valid.
REQ-011 fcs_ok / fcs_err  output  1 each  FCS check result, mutually exclusive, held until the next frame_done.
REQ-012 runt_err  output  1  frame_len < MIN_LEN, held like fcs_ok.
REQ-013 frame_len  output  16  accepted bytes in the last frame, FCS included.

Function
REQ-014 CRC SHALL be CRC-32 IEEE 802.3, reflected, polynomial 0x04C11DB7 (reflected 0xEDB88320), register initialised to 0xFFFFFFFF, one byte per accepted cycle.
REQ-015 The CRC SHALL run over every byte of the frame including FCS; the check passes iff the final register equals 0xDEBB20E3 (non-complemented residue).
REQ-016 FSM states SHALL be IDLE and RECV; IDLE->RECV on din_valid&din_sof; RECV->IDLE on din_valid&din_eof.
REQ-017 In IDLE, valid bytes without din_sof SHALL be discarded: no CRC update, no output.
REQ-018 din_sof in RECV SHALL abort the current frame without frame_done and restart the CRC and counter with that byte.
REQ-019 din_sof and din_eof in the same cycle SHALL form a 1-byte frame: frame_done, fcs_err=1, runt_err=1, frame_len=1.
REQ-020 frame_done SHALL assert exactly one cycle after the eof byte is accepted; fcs_ok, fcs_err, runt_err and frame_len update in that same cycle.
REQ-021 frame_len SHALL saturate at 16'hFFFF.
REQ-022 Bubbles SHALL freeze CRC, counter and FSM state.
REQ-023 Without stripping, dout/dout_valid/dout_sof/dout_eof SHALL be din and its qualifiers registered with 1-cycle latency, for bytes inside a frame only.

Reset
REQ-024 On rst_n low, the FSM SHALL go to IDLE, CRC to 0xFFFFFFFF, and all outputs to 0 (frame_len=0, fcs_ok=0, fcs_err=0), asynchronously.
REQ-025 Reset mid-frame SHALL discard the frame; no frame_done for it after release.

Configuration
REQ-026 Macro FCS_STRIP_EN defined: output SHALL pass through a 4-byte valid-advanced delay line so the 4 FCS bytes are never forwarded; dout_sof SHALL mark the first forwarded byte; dout_eof SHALL mark the byte shifted out when the eof byte arrives; frames of 4 or fewer bytes forward nothing.
REQ-027 Macro FCS_STRIP_EN undefined: REQ-023 behaviour; no delay line SHALL be synthesised.
REQ-028 The CRC check and result outputs SHALL be identical in both configurations.

Verification
REQ-029 ASCII "123456789" + 26 39 F4 CB, contiguous -> frame_done 1 cycle after eof, fcs_ok=1, frame_len=13, runt_err=1.
REQ-030 Same frame with bit0 of byte 5 flipped -> fcs_err=1, fcs_ok=0.
REQ-031 64-byte frame with correct FCS and random bubbles between bytes -> fcs_ok=1, runt_err=0, frame_len=64.
REQ-032 sof at byte 7 of a frame, then a valid 13-byte frame -> exactly one frame_done, fcs_ok=1, frame_len=13.
REQ-033 rst_n pulsed low at byte 6, then a valid frame -> one frame_done, fcs_ok=1; all outputs 0 during reset.
REQ-034 FCS_STRIP_EN, 13-byte frame -> 9 output bytes "123456789", dout_sof on '1', dout_eof on '9'; 4-byte frame -> no dout_valid.
